axis_pid_mc_v2_0: RTL

Time-multiplexed multichannel PI(D) regulator with AXI4-Stream input, reference and output ports, each channel tagged by `tdest`. It is the successor to the single-channel AXIS PI regulator. One shared multiply/accumulate datapath serves `channels` independent loops, with per-channel gains, per-channel integrator and anti-windup state, and synchronous per-channel integrator clear. It sits between the ADC/feedback stream and the modulator/actuator stream in the control fabric.

---
 rtl/axis_pid_mc_v2_0.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_pid_mc_v2_0.sv
// axis_pid_mc_v2_0: time-multiplexed multichannel PI(D) regulator with
// AXI4-Stream reference/feedback/output ports, channel selected by tdest.
// One shared datapath walks IDLE -> ERR -> MUL -> SUM -> OUT per update.
// Optional derivative term: define AXIS_PID_DERIVATIVE_EN.
module axis_pid_mc_v2_0 #(
    parameter int inout_width            = 16,
    parameter int inout_decimal_width    = 14,
    parameter int gain_width             = 16,
    parameter int gain_decimal_width     = 14,
    parameter int internal_width         = 32,
    parameter int internal_decimal_width = 24,
    parameter int channels               = 4,
    parameter int chan_width             = (channels > 1) ? $clog2(channels) : 1
) (
    input  logic                               aclk,
    input  logic                               resetn,
    input  logic [channels*gain_width-1:0]     kp,
    input  logic [channels*gain_width-1:0]     ki,
`ifdef AXIS_PID_DERIVATIVE_EN
    input  logic [channels*gain_width-1:0]     kd,
`endif
    input  logic signed [inout_width-1:0]      output_max,
    input  logic signed [inout_width-1:0]      output_min,
    input  logic [channels-1:0]                integrator_clear,
    input  logic signed [inout_width-1:0]      s_axis_reference_tdata,
    input  logic [chan_width-1:0]              s_axis_reference_tdest,
    input  logic                               s_axis_reference_tvalid,
    output logic                               s_axis_reference_tready,
    input  logic signed [inout_width-1:0]      s_axis_input_tdata,
    input  logic [chan_width-1:0]              s_axis_input_tdest,
    input  logic                               s_axis_input_tvalid,
    output logic                               s_axis_input_tready,
    output logic signed [inout_width-1:0]      m_axis_output_tdata,
    output logic [chan_width-1:0]              m_axis_output_tdest,
    output logic                               m_axis_output_tlast,
    output logic                               m_axis_output_tvalid,
    input  logic                               m_axis_output_tready
);

    localparam int EW  = inout_width + 1;   // error e = ref - input
    localparam int DEW = EW + 1;            // error difference e - e_prev
    localparam int PW  = DEW + gain_width;  // full-precision product
    // product realignment to the internal fixed-point format
    localparam int SH  = inout_decimal_width + gain_decimal_width - internal_decimal_width;
    localparam int SHR = (SH > 0) ? SH : 0;
    localparam int SHL = (SH < 0) ? -SH : 0;
    // I/O <-> internal format shift
    localparam int LS  = internal_decimal_width - inout_decimal_width;
    localparam int LSL = (LS > 0) ? LS : 0;
    localparam int LSR = (LS < 0) ? -LS : 0;
    // working width: wide enough that p + integ + d never wraps
    localparam int W0  = (PW > internal_width) ? PW : internal_width;
    localparam int W1  = (W0 > inout_width + LSL) ? W0 : inout_width + LSL;
    localparam int AW  = W1 + SHL + 3;

    localparam logic signed [AW-1:0] IMAX = AW'({1'b0, {(internal_width-1){1'b1}}});
    localparam logic signed [AW-1:0] IMIN = ~IMAX;

    function automatic logic signed [AW-1:0] align_prod(input logic signed [PW-1:0] v);
        return (AW'(v) >>> SHR) <<< SHL;
    endfunction

    function automatic logic signed [AW-1:0] io_to_int(input logic signed [inout_width-1:0] v);
        return (AW'(v) <<< LSL) >>> LSR;
    endfunction

    function automatic logic signed [inout_width-1:0] int_to_io(input logic signed [AW-1:0] v);
        return inout_width'((v >>> LSL) <<< LSR);
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_SUM, S_OUT} state_t;
    state_t state;

    logic signed [inout_width-1:0]    ref_mem   [channels];
    logic signed [internal_width-1:0] integ_mem [channels];
    logic [channels-1:0]              sat_hi_mem, sat_lo_mem;

    logic [chan_width-1:0]            ch_r;
    logic signed [inout_width-1:0]    x_r, r_r;
    logic signed [EW-1:0]             e_r;
    logic signed [internal_width-1:0] integ_r;
    logic                             shi_r, slo_r;
    logic signed [AW-1:0]             p_r, iinc_r;

    logic signed [gain_width-1:0]     g_p, g_i;
    logic signed [PW-1:0]             prod_p, prod_i;
    logic signed [AW-1:0]             integ_sum, integ_n, u, u_cl, lim_hi, lim_lo;
    logic                             do_int, u_hi, u_lo;
    logic signed [inout_width-1:0]    y;

`ifdef AXIS_PID_DERIVATIVE_EN
    logic signed [EW-1:0]             eprev_mem [channels];
    logic signed [EW-1:0]             eprev_r;
    logic signed [AW-1:0]             d_r;
    logic signed [gain_width-1:0]     g_d;
    logic signed [PW-1:0]             prod_d;
`endif

    // MUL stage: per-channel gain select and full-precision products
    always_comb begin
        g_p    = kp[ch_r*gain_width +: gain_width];
        g_i    = ki[ch_r*gain_width +: gain_width];
        prod_p = PW'(e_r) * PW'(g_p);
        prod_i = PW'(e_r) * PW'(g_i);
`ifdef AXIS_PID_DERIVATIVE_EN
        g_d    = kd[ch_r*gain_width +: gain_width];
        prod_d = PW'(DEW'(e_r) - DEW'(eprev_r)) * PW'(g_d);
`endif
    end

    // SUM stage: conditional integration with saturation, output clamp
    always_comb begin
        integ_sum = AW'(integ_r) + iinc_r;
        // integrate unless it would push further into the active limit
        do_int = (!shi_r && !slo_r) ||
                 (shi_r && iinc_r[AW-1]) ||
                 (slo_r && !iinc_r[AW-1] && (iinc_r != '0));
        if (!do_int)                integ_n = AW'(integ_r);
        else if (integ_sum > IMAX)  integ_n = IMAX;
        else if (integ_sum < IMIN)  integ_n = IMIN;
        else                        integ_n = integ_sum;
`ifdef AXIS_PID_DERIVATIVE_EN
        u = p_r + integ_n + d_r;
`else
        u = p_r + integ_n;
`endif
        lim_hi = io_to_int(output_max);
        lim_lo = io_to_int(output_min);
        u_hi   = (u > lim_hi);
        u_lo   = (u < lim_lo);
        u_cl   = u_hi ? lim_hi : (u_lo ? lim_lo : u);
        y      = int_to_io(u_cl);
    end

    // Update FSM, per-channel state storage, reference capture, clears
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state                   <= S_IDLE;
            s_axis_input_tready     <= 1'b0;
            s_axis_reference_tready <= 1'b0;
            m_axis_output_tdata     <= '0;
            m_axis_output_tdest     <= '0;
            m_axis_output_tlast     <= 1'b0;
            m_axis_output_tvalid    <= 1'b0;
            ch_r    <= '0;
            x_r     <= '0;
            r_r     <= '0;
            e_r     <= '0;
            integ_r <= '0;
            shi_r   <= 1'b0;
            slo_r   <= 1'b0;
            p_r     <= '0;
            iinc_r  <= '0;
            sat_hi_mem <= '0;
            sat_lo_mem <= '0;
            for (int n = 0; n < channels; n++) begin
                ref_mem[n]   <= '0;
                integ_mem[n] <= '0;
            end
`ifdef AXIS_PID_DERIVATIVE_EN
            eprev_r <= '0;
            d_r     <= '0;
            for (int n = 0; n < channels; n++) eprev_mem[n] <= '0;
`endif
        end else begin
            s_axis_reference_tready <= 1'b1;
            if (s_axis_reference_tvalid && s_axis_reference_tready &&
                int'(s_axis_reference_tdest) < channels)
                ref_mem[s_axis_reference_tdest] <= s_axis_reference_tdata;

            case (state)
                S_IDLE: begin
                    s_axis_input_tready <= 1'b1;
                    // out-of-range tdest is consumed here and never reaches the datapath
                    if (s_axis_input_tvalid && s_axis_input_tready &&
                        int'(s_axis_input_tdest) < channels) begin
                        ch_r  <= s_axis_input_tdest;
                        x_r   <= s_axis_input_tdata;
                        r_r   <= ref_mem[s_axis_input_tdest];
                        s_axis_input_tready <= 1'b0;
                        state <= S_ERR;
                    end
                end
                S_ERR: begin
                    e_r     <= EW'(r_r) - EW'(x_r);
                    integ_r <= integ_mem[ch_r];
                    shi_r   <= sat_hi_mem[ch_r];
                    slo_r   <= sat_lo_mem[ch_r];
`ifdef AXIS_PID_DERIVATIVE_EN
                    eprev_r <= eprev_mem[ch_r];
`endif
                    state   <= S_MUL;
                end
                S_MUL: begin
                    p_r    <= align_prod(prod_p);
                    iinc_r <= align_prod(prod_i);
`ifdef AXIS_PID_DERIVATIVE_EN
                    d_r    <= align_prod(prod_d);
`endif
                    state  <= S_SUM;
                end
                S_SUM: begin
                    integ_mem[ch_r]  <= internal_width'(integ_n);
                    sat_hi_mem[ch_r] <= u_hi;
                    sat_lo_mem[ch_r] <= u_lo;
`ifdef AXIS_PID_DERIVATIVE_EN
                    eprev_mem[ch_r]  <= e_r;
`endif
                    m_axis_output_tdata  <= y;
                    m_axis_output_tdest  <= ch_r;
                    m_axis_output_tlast  <= (ch_r == chan_width'(channels - 1));
                    m_axis_output_tvalid <= 1'b1;
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (m_axis_output_tready) begin
                        m_axis_output_tvalid <= 1'b0;
                        s_axis_input_tready  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // clear is applied last so it overrides a same-cycle SUM write
            for (int n = 0; n < channels; n++) begin
                if (integrator_clear[n]) begin
                    integ_mem[n]  <= '0;
                    sat_hi_mem[n] <= 1'b0;
                    sat_lo_mem[n] <= 1'b0;
`ifdef AXIS_PID_DERIVATIVE_EN
                    eprev_mem[n]  <= '0;
`endif
                end
            end
        end
    end

endmodule
